move_sequencer: RTL and testbench

Command-level controller that sequences the PID steering datapath of the Knight's-tour robot. It accepts one move command at a time, drives the PID's `moving`, `err_vld`, `error` and `frwrd` inputs, and turns the robot in place to the commanded heading. It then ramps forward speed up, counts IR line crossings to measure the commanded number of squares, ramps speed back down, and pulses a response when the move completes.

---
 rtl/move_sequencer.sv | 148 ++++++++++++++
 tb/tb_move_sequencer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/move_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : move_sequencer
//  Description : Command-level controller for the Knight's-tour robot PID
//                steering path. Accepts one move command, turns in place to
//                the commanded heading, ramps forward speed up, counts IR
//                line crossings, ramps speed down, then pulses a response.
//  Revision    : 1.0  initial release
// ============================================================================
module move_sequencer #(
    parameter logic [9:0]  MAX_FRWRD = 10'h2A0,
    parameter logic [9:0]  RAMP_INC  = 10'h010,
    parameter logic [11:0] HEAD_TOL  = 12'h02C
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_vld,
    input  logic [15:0] cmd,
    input  logic [11:0] heading,
    input  logic        heading_rdy,
    input  logic        cntrIR,
    output logic        clr_cmd_rdy,
    output logic        send_resp,
    output logic        moving,
    output logic        err_vld,
    output logic [11:0] error,
    output logic [9:0]  frwrd
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        TURN      = 2'd1,
        RAMP_UP   = 2'd2,
        RAMP_DOWN = 2'd3
    } state_t;

    localparam logic [9:0] RAMP_DEC = {RAMP_INC[8:0], 1'b0};

    state_t      state_q;
    logic [11:0] desired_q;
    logic [4:0]  target_q;
    logic [4:0]  lines_q;
    logic [9:0]  frwrd_q;
    logic        cntrIR_q;
    logic        clr_cmd_rdy_q;
    logic        send_resp_q;

    logic [11:0] err_abs;
    logic        settled;
    logic [10:0] frwrd_sum;
    logic [9:0]  frwrd_up_d;
    logic [9:0]  frwrd_dn_d;
    logic        line_edge;
    logic [4:0]  lines_d;
    logic        cmd_accept;
    logic [11:0] desired_d;

    assign error       = heading - desired_q;
    assign moving      = (state_q != IDLE);
    assign err_vld     = heading_rdy & moving;
    assign frwrd       = frwrd_q;
    assign clr_cmd_rdy = clr_cmd_rdy_q;
    assign send_resp   = send_resp_q;

    // Heading magnitude, speed ramp steps, line edge and command decode.
    always_comb begin
        // -2048 has no positive twin in 12 bits; saturate it to 2047
        if (error == 12'h800)
            err_abs = 12'h7FF;
        else if (error[11])
            err_abs = -error;
        else
            err_abs = error;
        settled    = heading_rdy && (err_abs < HEAD_TOL);

        frwrd_sum  = {1'b0, frwrd_q} + {1'b0, RAMP_INC};
        frwrd_up_d = (frwrd_sum > {1'b0, MAX_FRWRD}) ? MAX_FRWRD : frwrd_sum[9:0];
        frwrd_dn_d = (frwrd_q > RAMP_DEC) ? (frwrd_q - RAMP_DEC) : 10'd0;

        line_edge  = cntrIR & ~cntrIR_q;
        lines_d    = lines_q + 5'd1;

        cmd_accept = cmd_vld && (cmd[15:12] == 4'h2);
        desired_d  = (cmd[11:4] == 8'h00) ? 12'h000 : {cmd[11:4], 4'hF};
    end

    // Move state machine with registered speed and handshake pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            desired_q     <= 12'h000;
            target_q      <= 5'd0;
            lines_q       <= 5'd0;
            frwrd_q       <= 10'd0;
            cntrIR_q      <= 1'b0;
            clr_cmd_rdy_q <= 1'b0;
            send_resp_q   <= 1'b0;
        end else begin
            cntrIR_q      <= cntrIR;
            clr_cmd_rdy_q <= 1'b0;
            send_resp_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cmd_accept) begin
                        desired_q     <= desired_d;
                        target_q      <= {cmd[3:0], 1'b0};
                        lines_q       <= 5'd0;
                        frwrd_q       <= 10'd0;
                        clr_cmd_rdy_q <= 1'b1;
                        state_q       <= TURN;
                    end
                end
                TURN: begin
                    if (settled) begin
                        if (target_q == 5'd0) begin
                            state_q     <= IDLE;
                            send_resp_q <= 1'b1;
                        end else begin
                            state_q     <= RAMP_UP;
                        end
                    end
                end
                RAMP_UP: begin
                    if (heading_rdy)
                        frwrd_q <= frwrd_up_d;
                    if (line_edge) begin
                        lines_q <= lines_d;
                        if (lines_d == target_q)
                            state_q <= RAMP_DOWN;
                    end
                end
                RAMP_DOWN: begin
                    if (heading_rdy) begin
                        if (frwrd_q == 10'd0) begin
                            state_q     <= IDLE;
                            send_resp_q <= 1'b1;
                        end else begin
                            frwrd_q     <= frwrd_dn_d;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_move_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_move_sequencer
//  Description : Scoreboard bench for move_sequencer with a behavioural
//                reference model driven by directed and random moves.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_move_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_vld = 1'b0;
    logic [15:0] cmd = 16'h0000;
    logic [11:0] heading = 12'h000;
    logic        heading_rdy = 1'b0;
    logic        cntrIR = 1'b0;
    logic        clr_cmd_rdy, send_resp, moving, err_vld;
    logic [11:0] error;
    logic [9:0]  frwrd;

    move_sequencer dut (
        .clk(clk), .rst_n(rst_n), .cmd_vld(cmd_vld), .cmd(cmd),
        .heading(heading), .heading_rdy(heading_rdy), .cntrIR(cntrIR),
        .clr_cmd_rdy(clr_cmd_rdy), .send_resp(send_resp), .moving(moving),
        .err_vld(err_vld), .error(error), .frwrd(frwrd)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] err;
        logic [9:0]  frwrd;
        logic        resp;
        logic        mov;
    } item_t;

    item_t q[$];
    int    acc_q[$];
    int    checks = 0;
    int    errors = 0;

    localparam int M_IDLE = 0, M_TURN = 1, M_UP = 2, M_DOWN = 3;
    int m_mode = M_IDLE, m_frwrd = 0, m_lines = 0, m_target = 0, m_desired = 0;
    bit m_irprev = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s t=%0t", name, $time);
    endtask

    // One clock of stimulus; the model predicts the effect of the next edge.
    task automatic cyc(input bit cv, input logic [15:0] c, input bit hr,
                       input logic [11:0] h, input bit ir);
        int    err, serr, mag, old;
        bit    rise, resp;
        item_t it;
        @(posedge clk); #1;
        cmd_vld = cv; cmd = c; heading_rdy = hr; heading = h; cntrIR = ir;
        err  = (int'(h) - m_desired) & 32'hFFF;
        serr = (err >= 2048) ? err - 4096 : err;
        mag  = (serr < 0) ? -serr : serr;
        if (mag > 2047) mag = 2047;
        rise = ir && !m_irprev;
        m_irprev = ir;
        resp = 1'b0;
        old  = m_mode;
        if (old == M_IDLE) begin
            if (cv && c[15:12] == 4'h2) begin
                m_desired = (c[11:4] == 8'h00) ? 0 : int'(c[11:4]) * 16 + 15;
                m_target  = 2 * int'(c[3:0]);
                m_lines   = 0;
                m_frwrd   = 0;
                m_mode    = M_TURN;
                acc_q.push_back(1);
            end
        end else if (old == M_TURN) begin
            if (hr && mag < 44) begin
                if (m_target == 0) begin
                    m_mode = M_IDLE;
                    resp   = 1'b1;
                end else begin
                    m_mode = M_UP;
                end
            end
        end else if (old == M_UP) begin
            if (hr) m_frwrd = (m_frwrd + 16 > 672) ? 672 : m_frwrd + 16;
            if (rise) begin
                m_lines++;
                if (m_lines == m_target) m_mode = M_DOWN;
            end
        end else begin
            if (hr) begin
                if (m_frwrd == 0) begin
                    m_mode = M_IDLE;
                    resp   = 1'b1;
                end else begin
                    m_frwrd = (m_frwrd > 32) ? m_frwrd - 32 : 0;
                end
            end
        end
        if (old != M_IDLE && hr) begin
            it.err   = err[11:0];
            it.frwrd = m_frwrd[9:0];
            it.resp  = resp;
            it.mov   = (m_mode != M_IDLE);
            q.push_back(it);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 16'h0, 1'b0, 12'h000, 1'b0);
    endtask

    // Heading close to the latched target, within +/-40.
    function automatic logic [11:0] near_head();
        int off;
        off = int'($urandom_range(0, 80)) - 40;
        return 12'(m_desired + off);
    endfunction

    task automatic strobe(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 16'h0, 1'b1, near_head(), m_irprev);
    endtask

    task automatic ir_pulse(input int hold);
        for (int i = 0; i < hold; i++) cyc(1'b0, 16'h0, 1'b0, near_head(), 1'b1);
        for (int i = 0; i < hold; i++) cyc(1'b0, 16'h0, 1'b0, near_head(), 1'b0);
    endtask

    task automatic finish_down();
        for (int i = 0; i < 100 && m_mode != M_IDLE; i++) strobe(1);
    endtask

    task automatic do_reset(input int n);
        logic [11:0] hv;
        idle(1);
        @(posedge clk); #1;
        hv = 12'($urandom);
        rst_n = 1'b0; cmd_vld = 1'b0; cmd = 16'h0; heading = hv;
        heading_rdy = 1'b1; cntrIR = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_mode = M_IDLE; m_frwrd = 0; m_lines = 0; m_target = 0;
        m_desired = 0; m_irprev = 1'b0;
        chk("rst_frwrd", int'(frwrd), 0);
        chk("rst_moving", int'(moving), 0);
        chk("rst_err_vld", int'(err_vld), 0);
        chk("rst_send_resp", int'(send_resp), 0);
        chk("rst_clr_cmd_rdy", int'(clr_cmd_rdy), 0);
        chk("rst_error_eq_heading", int'(error), int'(hv));
    endtask

    // Monitor: resolves each err_vld sample against the scoreboard.
    bit    pend = 1'b0;
    bit    prev_clr = 1'b0;
    item_t pi;
    always @(negedge clk) begin
        if (rst_n) begin
            if (pend) begin
                chk("frwrd", int'(frwrd), int'(pi.frwrd));
                chk("send_resp", int'(send_resp), int'(pi.resp));
                chk("moving", int'(moving), int'(pi.mov));
                pend = 1'b0;
            end else if (send_resp) begin
                fail_now("unexpected_send_resp");
            end
            if (clr_cmd_rdy) begin
                if (acc_q.size() == 0) fail_now("unexpected_clr_cmd_rdy");
                else void'(acc_q.pop_front());
                chk("accept_moving", int'(moving), 1);
                chk("clr_cmd_rdy_one_cycle", int'(prev_clr), 0);
            end
            prev_clr = clr_cmd_rdy;
            if (err_vld) begin
                if (q.size() == 0) begin
                    fail_now("unexpected_err_vld");
                end else begin
                    pi = q.pop_front();
                    chk("error", int'(error), int'(pi.err));
                    pend = 1'b1;
                end
            end
        end
    end

    initial begin
        logic [15:0] c;
        bit          ir;
        // Reset, then a non-move opcode must be ignored
        do_reset(2);
        cyc(1'b1, 16'h5123, 1'b0, 12'h000, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 16'h0, 1'b1, 12'h000, 1'b0);

        // Turn only: heading far from target, then settled
        cyc(1'b1, 16'h23F0, 1'b0, 12'h000, 1'b0);
        for (int i = 0; i < 2; i++) cyc(1'b0, 16'h0, 1'b1, 12'h000, 1'b0);
        cyc(1'b0, 16'h0, 1'b1, 12'h3E0, 1'b0);
        idle(3);

        // Ramp saturation over 50 strobes, then two lines and ramp down
        cyc(1'b1, 16'h2001, 1'b0, 12'h000, 1'b0);
        strobe(1);
        strobe(50);
        ir_pulse(3);
        ir_pulse(3);
        finish_down();
        idle(2);

        // Line counting with IR edges during TURN ignored, ignored cmd in ramp down
        cyc(1'b1, 16'h2802, 1'b0, 12'h000, 1'b0);
        for (int i = 0; i < 2; i++) begin
            cyc(1'b0, 16'h0, 1'b1, 12'h000, 1'b1);
            cyc(1'b0, 16'h0, 1'b0, 12'h000, 1'b1);
            cyc(1'b0, 16'h0, 1'b1, 12'h000, 1'b0);
        end
        strobe(1);
        for (int i = 0; i < 4; i++) begin
            strobe(3);
            ir_pulse(4);
        end
        cyc(1'b1, 16'h2001, 1'b1, near_head(), 1'b0);
        finish_down();
        idle(2);

        // Mid-move reset at frwrd = 0x80
        cyc(1'b1, 16'h2003, 1'b0, 12'h000, 1'b0);
        strobe(1);
        strobe(8);
        do_reset(1);
        idle(4);

        // Random moves, including back-to-back commands and coincident edges
        ir = 1'b0;
        for (int n = 0; n < 20; n++) begin
            c = {4'h2, (($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom)),
                 4'($urandom_range(0, 3))};
            if ($urandom_range(0, 3) == 0)
                cyc(1'b1, {4'($urandom_range(3, 15)), c[11:0]}, 1'b0, 12'($urandom), ir);
            cyc(1'b1, c, 1'b0, 12'($urandom), ir);
            for (int k = 0; k < 3000 && m_mode != M_IDLE; k++) begin
                if ($urandom_range(0, 3) == 0) ir = ~ir;
                cyc(($urandom_range(0, 7) == 0), 16'($urandom),
                    ($urandom_range(0, 2) == 0),
                    ($urandom_range(0, 1) == 0) ? near_head() : 12'($urandom), ir);
            end
            if (m_mode != M_IDLE) do_reset(1);
        end
        idle(3);

        chk("scoreboard_empty", q.size(), 0);
        chk("accept_queue_empty", acc_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
